// File: rtl/branch_resolve_unit.sv
// Branch resolve unit (execute stage).
// Takes the resolved condition bit of an issued branch and computes its target. With
// DELAY_SLOT=1 it tracks the architectural delay slot and annuls it for not-taken "likely"
// branches. A taken branch produces a held PC redirect to fetch over valid/ready. It also
// keeps saturating branch/taken counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   br_valid/br_bf/br_cond   branch issue pulse, function code, condition result
//   br_pc/br_imm             branch PC and raw 16-bit offset field
//   slot_valid               delay-slot instruction in execute
//   redir_valid/pc/ready     redirect handshake to fetch
//   annul_slot               kill the delay-slot instruction (combinational)
//   busy                     stall decode from issuing another branch
//   err                      sticky: branch issued while busy
//   branch_cnt/taken_cnt     saturating performance counters
module branch_resolve_unit #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned DELAY_SLOT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   input  logic [3:0]       br_bf,
   input  logic             br_cond,
   input  logic [31:0]      br_pc,
   input  logic [15:0]      br_imm,
   input  logic             slot_valid,
   output logic             redir_valid,
   output logic [31:0]      redir_pc,
   input  logic             redir_ready,
   output logic             annul_slot,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {StIdle, StSlotWait, StRedirect} state_e;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic             taken_q, taken_d;
   logic             annul_q, annul_d;
   logic [31:0]      target_q, target_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   logic        code_ok;
   logic        likely;
   logic [31:0] target_calc;

   assign code_ok     = (br_bf == 4'b0010) || (br_bf == 4'b0011) || br_bf[3];
   assign likely      = br_bf[3] & br_bf[0];
   // Offset is a word count: sign-extend, scale by 4, relative to PC+4. Wraps mod 2^32.
   assign target_calc = br_pc + 32'd4 + {{14{br_imm[15]}}, br_imm, 2'b00};

   always_comb begin
      state_d      = state_q;
      taken_d      = taken_q;
      annul_d      = annul_q;
      target_d     = target_q;
      err_d        = err_q;
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;

      // Issuing while busy is dropped but remembered as a protocol error.
      if (br_valid && (state_q != StIdle)) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (br_valid && code_ok) begin
               branch_cnt_d = (branch_cnt_q == CntMax) ? branch_cnt_q : branch_cnt_q + CntOne;
               if (br_cond) begin
                  taken_cnt_d = (taken_cnt_q == CntMax) ? taken_cnt_q : taken_cnt_q + CntOne;
                  target_d    = target_calc;
                  taken_d     = 1'b1;
               end else if (likely && (DELAY_SLOT != 0)) begin
                  annul_d = 1'b1;
               end
               if (DELAY_SLOT != 0) begin
                  // A taken branch or a not-taken likely branch both need the slot.
                  if (br_cond || likely) state_d = StSlotWait;
               end else if (br_cond) begin
                  state_d = StRedirect;
               end
            end
         end
         StSlotWait: begin
            if (slot_valid) begin
               state_d = taken_q ? StRedirect : StIdle;
               taken_d = 1'b0;
               annul_d = 1'b0;
            end
         end
         StRedirect: begin
            taken_d = 1'b0;
            if (redir_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         taken_q      <= 1'b0;
         annul_q      <= 1'b0;
         target_q     <= 32'd0;
         err_q        <= 1'b0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         taken_q      <= taken_d;
         annul_q      <= annul_d;
         target_q     <= target_d;
         err_q        <= err_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   assign redir_valid = (state_q == StRedirect);
   assign redir_pc    = target_q;
   assign annul_slot  = (state_q == StSlotWait) && slot_valid && annul_q;
   assign busy        = (state_q != StIdle);
   assign err         = err_q;
   assign branch_cnt  = branch_cnt_q;
   assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a queue-based reference model.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        br_valid = 1'b0;
   logic [3:0]  br_bf = 4'd0;
   logic        br_cond = 1'b0;
   logic [31:0] br_pc = 32'd0;
   logic [15:0] br_imm = 16'd0;
   logic        slot_valid = 1'b0;
   logic        redir_ready = 1'b0;

   logic        redir_valid, annul_slot, busy, err;
   logic [31:0] redir_pc;
   logic [15:0] branch_cnt, taken_cnt;

   logic        s_redir_valid, s_annul_slot, s_busy, s_err;
   logic [31:0] s_redir_pc;
   logic [1:0]  s_branch_cnt, s_taken_cnt;

   logic        n_redir_valid, n_annul_slot, n_busy, n_err;
   logic [31:0] n_redir_pc;
   logic [15:0] n_branch_cnt, n_taken_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.CNT_W(16), .DELAY_SLOT(1)) dut (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_bf(br_bf), .br_cond(br_cond),
      .br_pc(br_pc), .br_imm(br_imm), .slot_valid(slot_valid), .redir_valid(redir_valid),
      .redir_pc(redir_pc), .redir_ready(redir_ready), .annul_slot(annul_slot), .busy(busy),
      .err(err), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   branch_resolve_unit #(.CNT_W(2), .DELAY_SLOT(1)) dut_s (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_bf(br_bf), .br_cond(br_cond),
      .br_pc(br_pc), .br_imm(br_imm), .slot_valid(slot_valid), .redir_valid(s_redir_valid),
      .redir_pc(s_redir_pc), .redir_ready(redir_ready), .annul_slot(s_annul_slot),
      .busy(s_busy), .err(s_err), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
   );

   branch_resolve_unit #(.CNT_W(16), .DELAY_SLOT(0)) dut_n (
      .clk(clk), .rst(rst), .br_valid(br_valid), .br_bf(br_bf), .br_cond(br_cond),
      .br_pc(br_pc), .br_imm(br_imm), .slot_valid(slot_valid), .redir_valid(n_redir_valid),
      .redir_pc(n_redir_pc), .redir_ready(redir_ready), .annul_slot(n_annul_slot),
      .busy(n_busy), .err(n_err), .branch_cnt(n_branch_cnt), .taken_cnt(n_taken_cnt)
   );

   typedef struct {
      logic [3:0]  bf;
      logic        cond;
      logic [31:0] pc;
      logic [15:0] imm;
      logic        counted;
      logic        wait_slot;
      logic        annul;
      logic        redir;
      logic [31:0] target;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      br_valid = 1'b0; slot_valid = 1'b0; redir_ready = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic issue(input logic [3:0] bf, input logic cond, input logic [31:0] pc,
                        input logic [15:0] imm);
      br_valid = 1'b1; br_bf = bf; br_cond = cond; br_pc = pc; br_imm = imm;
   endtask

   // Reference model state: pending slot, queued redirects and counters.
   bit          m_slot_pending;
   bit          m_annul;
   logic [31:0] m_slot_tgt[$];
   logic [31:0] m_redir_q[$];
   bit          m_err;
   int          m_bc, m_tc;

   function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
      int off;
      off = int'($signed(imm)) * 4;
      return pc + 32'd4 + 32'(off);
   endfunction

   function automatic bit ref_code_ok(input logic [3:0] bf);
      return (bf == 4'd2) || (bf == 4'd3) || (bf >= 4'd8);
   endfunction

   int exp_bc, exp_tc;

   initial begin
      // ---------------- Reset state ----------------
      do_reset();
      chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
      chk("rst_redir_pc", redir_pc, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
      chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);

      // ---------------- Vector table ----------------
      vecs[0] = '{4'b1000, 1'b1, 32'h0040_0000, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0014};
      vecs[1] = '{4'b1011, 1'b0, 32'h0040_0000, 16'h0008, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[2] = '{4'b0010, 1'b0, 32'h0040_0000, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{4'b0011, 1'b1, 32'h0040_0010, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0010};
      vecs[4] = '{4'b1100, 1'b1, 32'hFFFF_FFFC, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0004};
      vecs[5] = '{4'b0100, 1'b1, 32'h0000_1000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{4'b1111, 1'b1, 32'h0000_2000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFE_2004};
      vecs[7] = '{4'b1001, 1'b0, 32'h0000_3000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[8] = '{4'b1010, 1'b0, 32'h0000_3000, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[9] = '{4'b0000, 1'b1, 32'h0000_4000, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      exp_bc = 0; exp_tc = 0;
      redir_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].bf, vecs[i].cond, vecs[i].pc, vecs[i].imm);
         slot_valid = 1'b1;  // same-cycle slot must be ignored
         #1;
         chk($sformatf("v%0d_issue_busy", i), {31'd0, busy}, 32'd0);
         chk($sformatf("v%0d_issue_annul", i), {31'd0, annul_slot}, 32'd0);
         step();
         br_valid = 1'b0; slot_valid = 1'b0;
         chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].wait_slot});
         slot_valid = 1'b1;
         #1;
         chk($sformatf("v%0d_annul", i), {31'd0, annul_slot}, {31'd0, vecs[i].annul});
         step();
         slot_valid = 1'b0;
         chk($sformatf("v%0d_redir_valid", i), {31'd0, redir_valid}, {31'd0, vecs[i].redir});
         if (vecs[i].redir) chk($sformatf("v%0d_redir_pc", i), redir_pc, vecs[i].target);
         step();
         chk($sformatf("v%0d_done_busy", i), {31'd0, busy}, 32'd0);
         exp_bc += int'(vecs[i].counted);
         exp_tc += int'(vecs[i].redir);
         chk($sformatf("v%0d_branch_cnt", i), {16'd0, branch_cnt}, 32'(exp_bc));
         chk($sformatf("v%0d_taken_cnt", i), {16'd0, taken_cnt}, 32'(exp_tc));
      end

      // ---------------- Slot two cycles later, then 5 cycles of backpressure ----------------
      do_reset();
      issue(4'b1000, 1'b1, 32'h0040_0000, 16'h0004);
      step();
      br_valid = 1'b0;
      chk("bp_busy_after_issue", {31'd0, busy}, 32'd1);
      chk("bp_no_early_redir", {31'd0, redir_valid}, 32'd0);
      step();
      slot_valid = 1'b1;
      #1;
      chk("bp_annul_taken", {31'd0, annul_slot}, 32'd0);
      step();
      slot_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_hold_valid%0d", k), {31'd0, redir_valid}, 32'd1);
         chk($sformatf("bp_hold_pc%0d", k), redir_pc, 32'h0040_0014);
         step();
      end
      redir_ready = 1'b1;
      #1;
      chk("bp_ready_valid", {31'd0, redir_valid}, 32'd1);
      step();
      chk("bp_done_busy", {31'd0, busy}, 32'd0);
      chk("bp_done_valid", {31'd0, redir_valid}, 32'd0);
      chk("bp_branch_cnt", {16'd0, branch_cnt}, 32'd1);
      chk("bp_taken_cnt", {16'd0, taken_cnt}, 32'd1);

      // ---------------- Violation in SLOT_WAIT, then reset mid-redirect ----------------
      do_reset();
      issue(4'b1001, 1'b1, 32'h0000_0100, 16'h0010);
      step();
      issue(4'b1000, 1'b1, 32'h0000_0900, 16'h0040);
      step();
      br_valid = 1'b0;
      chk("viol_err", {31'd0, err}, 32'd1);
      chk("viol_branch_cnt", {16'd0, branch_cnt}, 32'd1);
      chk("viol_taken_cnt", {16'd0, taken_cnt}, 32'd1);
      chk("viol_busy", {31'd0, busy}, 32'd1);
      slot_valid = 1'b1;
      #1;
      chk("viol_annul_likely_taken", {31'd0, annul_slot}, 32'd0);
      step();
      slot_valid = 1'b0;
      chk("viol_redir_valid", {31'd0, redir_valid}, 32'd1);
      chk("viol_redir_pc", redir_pc, 32'h0000_0144);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_redir_valid", {31'd0, redir_valid}, 32'd0);
      chk("mid_rst_redir_pc", redir_pc, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      chk("mid_rst_cnts", {branch_cnt, taken_cnt}, 32'd0);
      step();
      chk("mid_rst_stays_idle", {31'd0, redir_valid}, 32'd0);

      // ---------------- No delay slot variant ----------------
      do_reset();
      redir_ready = 1'b1;
      issue(4'b1000, 1'b1, 32'h0040_0000, 16'h0004);
      step();
      br_valid = 1'b0;
      chk("nds_redir_valid", {31'd0, n_redir_valid}, 32'd1);
      chk("nds_redir_pc", n_redir_pc, 32'h0040_0014);
      chk("nds_busy", {31'd0, n_busy}, 32'd1);
      step();
      chk("nds_done_valid", {31'd0, n_redir_valid}, 32'd0);
      chk("nds_done_busy", {31'd0, n_busy}, 32'd0);
      issue(4'b1011, 1'b0, 32'h0040_0000, 16'h0004);
      step();
      br_valid = 1'b0;
      chk("nds_likely_nt_busy", {31'd0, n_busy}, 32'd0);
      slot_valid = 1'b1;
      #1;
      chk("nds_no_annul", {31'd0, n_annul_slot}, 32'd0);
      step();
      slot_valid = 1'b0;
      chk("nds_cnts", {n_branch_cnt, n_taken_cnt}, {16'd2, 16'd1});

      // ---------------- Counter saturation (CNT_W=2) ----------------
      do_reset();
      redir_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         issue(4'b1000, 1'b1, 32'h0000_1000, 16'h0001);
         step();
         br_valid = 1'b0;
         slot_valid = 1'b1;
         step();
         slot_valid = 1'b0;
         step();
      end
      chk("sat_branch_cnt", {30'd0, s_branch_cnt}, 32'd3);
      chk("sat_taken_cnt", {30'd0, s_taken_cnt}, 32'd3);
      chk("wide_branch_cnt", {16'd0, branch_cnt}, 32'd5);
      chk("wide_taken_cnt", {16'd0, taken_cnt}, 32'd5);

      // ---------------- Randomized run against the reference model ----------------
      do_reset();
      m_slot_pending = 0; m_annul = 0; m_err = 0; m_bc = 0; m_tc = 0;
      m_slot_tgt.delete(); m_redir_q.delete();
      for (int c = 0; c < 800; c++) begin
         bit m_busy, exp_annul, ok, lk;
         logic [31:0] tgt;
         m_busy = m_slot_pending || (m_redir_q.size() != 0);
         br_valid = ($urandom_range(0, 3) == 0);
         br_bf = 4'($urandom_range(0, 15));
         if (m_busy) br_bf = {1'b1, 3'($urandom_range(0, 7))};
         br_cond = 1'($urandom_range(0, 1));
         br_pc = $urandom;
         br_imm = 16'($urandom);
         slot_valid = ($urandom_range(0, 2) == 0);
         redir_ready = 1'($urandom_range(0, 1));
         #1;
         exp_annul = m_slot_pending && slot_valid && m_annul;
         chk("rnd_busy", {31'd0, busy}, {31'd0, m_busy});
         chk("rnd_redir_valid", {31'd0, redir_valid}, {31'd0, (m_redir_q.size() != 0)});
         if (m_redir_q.size() != 0) chk("rnd_redir_pc", redir_pc, m_redir_q[0]);
         chk("rnd_annul", {31'd0, annul_slot}, {31'd0, exp_annul});
         chk("rnd_err", {31'd0, err}, {31'd0, m_err});
         chk("rnd_cnts", {branch_cnt, taken_cnt}, {16'(m_bc), 16'(m_tc)});
         if (br_valid && m_busy) m_err = 1;
         if (m_redir_q.size() != 0) begin
            if (redir_ready) void'(m_redir_q.pop_front());
         end else if (m_slot_pending) begin
            if (slot_valid) begin
               m_slot_pending = 0;
               m_annul = 0;
               if (m_slot_tgt.size() != 0) m_redir_q.push_back(m_slot_tgt.pop_front());
            end
         end else if (br_valid && ref_code_ok(br_bf)) begin
            ok = 1;
            lk = br_bf[3] && br_bf[0];
            tgt = ref_target(br_pc, br_imm);
            if (m_bc < 65535) m_bc++;
            if (br_cond) begin
               if (m_tc < 65535) m_tc++;
               m_slot_tgt.push_back(tgt);
            end
            if (ok && (br_cond || lk)) begin
               m_slot_pending = 1;
               m_annul = !br_cond && lk;
            end
         end
         step();
      end
      br_valid = 1'b0; slot_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer of the branch-condition result in the execute stage.
- Takes the condition bit for an issued branch and computes the target. It tracks the architectural delay slot and annuls that slot for not-taken "likely" branches.
- Issues a held PC redirect to fetch over a valid/ready handshake.
- Keeps saturating branch/taken performance counters.

Parameters:
- CNT_W, 16, width of the performance counters.
- DELAY_SLOT, 1: 1 = MIPS delay-slot semantics; 0 = redirect immediately, no slot tracking, no annul.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- br_valid  in  1  one-cycle pulse: branch instruction in execute this cycle
- br_bf  in  4  branch function code (same encoding as condition unit)
- br_cond  in  1  condition result for this branch (1 = condition true)
- br_pc  in  32  PC of the branch instruction
- br_imm  in  16  raw branch offset field
- slot_valid  in  1  pulse: delay-slot instruction has entered execute
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect target, stable while redir_valid
- redir_ready  in  1  fetch accepts redirect
- annul_slot  out  1  kill delay-slot instruction (combinational, valid with slot_valid)
- busy  out  1  stall decode from issuing another branch
- err  out  1  sticky protocol-violation flag
- branch_cnt  out  CNT_W  accepted branches
- taken_cnt  out  CNT_W  taken branches

Behaviour:
- Valid codes:
  - 0010 BLTZ, 0011 BGEZ.
  - 1000..1111 two-operand/compare class.
  - Likely flag = br_bf[3] & br_bf[0].
  - Any other code with br_valid: ignored, no counter change, no err.
- Target = br_pc + 4 + (sign_extend(br_imm) << 2), modulo 2^32; wrap-around silently.
- States: IDLE, SLOT_WAIT, REDIRECT.
- IDLE (busy=0):
  - On br_valid with a valid code:
    - Increment branch_cnt.
    - If br_cond, increment taken_cnt, latch target, set taken flag.
    - If !br_cond and likely, set annul flag.
  - Next state:
    - DELAY_SLOT=1 and (taken or annul): SLOT_WAIT.
    - DELAY_SLOT=0 and taken: REDIRECT.
    - Otherwise: stay IDLE.
  - slot_valid in IDLE, or in the same cycle as br_valid: ignored.
- SLOT_WAIT (busy=1):
  - Waits indefinitely for slot_valid.
  - On slot_valid: annul_slot = annul flag (same cycle, combinational).
  - Next state: REDIRECT if taken, else IDLE. Flags clear on leaving.
- REDIRECT (busy=1):
  - redir_valid=1, redir_pc = latched target, held unchanged until redir_ready.
  - Cycle with redir_valid & redir_ready: transfer completes, next state IDLE.
  - redir_valid drops the following cycle.
- Latency:
  - DELAY_SLOT=1: slot_valid in cycle N means redir_valid in N+1.
  - DELAY_SLOT=0: br_valid in cycle N means redir_valid in N+1.
- Annul never asserts for non-likely or taken branches; annul_slot=0 outside SLOT_WAIT.
- br_valid while busy=1:
  - Ignored: no counter, state or target change.
  - err set and held until rst.
- Counters increment by 1 and saturate at 2^CNT_W-1.
- Reset (any state, including mid-redirect):
  - State IDLE; flags cleared.
  - redir_valid=0, redir_pc=0, annul_slot=0, busy=0, err=0, both counters=0.
  - A pending redirect is dropped.

Test Plan:
- Taken BEQ with slot, immediate ready:
  - Stimulus: br_pc=0x00400000, br_imm=0x0004, bf=1000, cond=1; slot_valid 2 cycles later; redir_ready=1.
  - Response: busy=1 from cycle after br_valid. redir_valid=1 with redir_pc=0x00400014 one cycle after slot_valid, then IDLE. branch_cnt=1, taken_cnt=1.
- Backpressure:
  - Stimulus: same as above with redir_ready=0 for 5 cycles.
  - Response: redir_valid and redir_pc=0x00400014 held 5 cycles. Completes on the ready cycle; busy clears next cycle.
- Likely not taken:
  - Stimulus: bf=1011, cond=0, then slot_valid.
  - Response: annul_slot=1 exactly in the slot_valid cycle, no redirect, branch_cnt=1, taken_cnt=0.
- Non-likely not taken:
  - Stimulus: bf=0010, cond=0.
  - Response: stays IDLE, busy=0, no annul_slot on a later slot_valid.
- Target arithmetic:
  - br_pc=0x00400010, imm=0xFFFF gives 0x00400010.
  - br_pc=0xFFFFFFFC, imm=0x0001 gives 0x00000004.
- Violations and reset:
  - br_valid during SLOT_WAIT gives err=1, counters unchanged.
  - rst asserted during REDIRECT gives redir_valid=0 next cycle, all outputs at reset values.
  - With CNT_W=2, 5 taken branches give branch_cnt=taken_cnt=3.
